// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// writeback selects, FSM states and the access legality check.
package mem_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_t;

    // True when an access with this funct3/offset must not reach the bus:
    // unknown size, unsigned store, or an offset not aligned to the size.
    function automatic logic lsu_bad(input logic [2:0] op,
                                     input logic [1:0] addr_lo,
                                     input logic       is_store);
        logic bad;
        case (op)
            LSU_B:   bad = 1'b0;
            LSU_H:   bad = addr_lo[0];
            LSU_W:   bad = |addr_lo;
            LSU_BU:  bad = is_store;
            LSU_HU:  bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane logic shared by stores and loads: byte enables, replicated
// write data, extracted/extended load value and the illegal-access flag.
module lsu_align (
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic        bad
);
    import mem_lsu_pkg::*;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path through the case statements can infer a latch.
    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            2'd3:    lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = 4'b0000;
        wdata      = store_data;
        load_value = '0;
        case (op)
            LSU_B: begin
                be         = 4'b0001 << addr_lo;
                wdata      = {4{store_data[7:0]}};
                load_value = {{24{lane_b[7]}}, lane_b};
            end
            LSU_BU: begin
                be         = 4'b0001 << addr_lo;
                load_value = {24'b0, lane_b};
            end
            LSU_H: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_value = {{16{lane_h[15]}}, lane_h};
            end
            LSU_HU: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_value = {16'b0, lane_h};
            end
            LSU_W: begin
                be         = 4'b1111;
                load_value = rdata;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    assign bad = lsu_bad(op, addr_lo, is_store);

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: EX/MEM pipeline register, req/ack data-bus FSM with timeout,
// and load-data capture. Stalls the front end while an access is pending.
module mem_lsu #(
    parameter int DATA_WITDH  = 32,
    parameter int ADDR_WITDH  = 32,
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_wee,
    input  logic [2:0]            ope,
    input  logic                  mem_wee,
    input  logic [1:0]            wb_ctre,
    input  logic [4:0]            rde,
    input  logic [ADDR_WITDH-1:0] pcne,
    input  logic [DATA_WITDH-1:0] alu_result,
    input  logic [DATA_WITDH-1:0] rd2_ture,
    output logic                  reg_wem,
    output logic [4:0]            rdm,
    output logic [1:0]            wb_ctrm,
    output logic [ADDR_WITDH-1:0] pcnm,
    output logic [DATA_WITDH-1:0] alu_resultm,
    output logic [DATA_WITDH-1:0] load_data,
    output logic                  mem_stall,
    output logic                  lsu_fault,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [ADDR_WITDH-1:0] dbus_addr,
    output logic [3:0]            dbus_be,
    output logic [DATA_WITDH-1:0] dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [DATA_WITDH-1:0] dbus_rdata
);
    import mem_lsu_pkg::*;

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    lsu_state_t state, state_nxt;

    logic                  reg_we_q, mem_we_q;
    logic [2:0]            op_q;
    logic [1:0]            wb_ctr_q;
    logic [4:0]            rd_q;
    logic [ADDR_WITDH-1:0] pcn_q;
    logic [DATA_WITDH-1:0] alu_q, store_data_q, load_data_q;
    logic [CNT_W-1:0]      cnt;
    logic                  timed_out;

    logic                  in_access, stall_c, timeout_hit;
    logic                  access_e, bad_e, access_m, bad_m, misalign_m;
    logic [3:0]            be_m;
    logic [31:0]           wdata_m, load_value_m;

    // A bundle only enters ACCESS if it will actually reach the bus.
    assign access_e    = mem_wee | (wb_ctre == WB_MEM);
    assign bad_e       = lsu_bad(ope, alu_result[1:0], mem_wee);
    assign access_m    = mem_we_q | (wb_ctr_q == WB_MEM);
    assign misalign_m  = access_m & bad_m;
    assign timeout_hit = (cnt == CNT_W'(BUS_TIMEOUT - 1));

    lsu_align u_align (
        .op         (op_q),
        .addr_lo    (alu_q[1:0]),
        .is_store   (mem_we_q),
        .store_data (store_data_q),
        .rdata      (dbus_rdata),
        .be         (be_m),
        .wdata      (wdata_m),
        .load_value (load_value_m),
        .bad        (bad_m)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = (access_e && !bad_e) ? ACCESS : IDLE;
            ACCESS: begin
                if (dbus_ack)         state_nxt = (access_e && !bad_e) ? ACCESS : IDLE;
                else if (timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_access = 1'b0;
        stall_c   = 1'b0;
        if (state == ACCESS) begin
            in_access = 1'b1;
            stall_c   = !dbus_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_we_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            op_q         <= '0;
            wb_ctr_q     <= '0;
            rd_q         <= '0;
            pcn_q        <= '0;
            alu_q        <= '0;
            store_data_q <= '0;
        end else if (!stall_c) begin
            reg_we_q     <= reg_wee;
            mem_we_q     <= mem_wee;
            op_q         <= ope;
            wb_ctr_q     <= wb_ctre;
            rd_q         <= rde;
            pcn_q        <= pcne;
            alu_q        <= alu_result;
            store_data_q <= rd2_ture;
        end
    end

    // timed_out marks the single cycle after an abort, while the aborted
    // instruction is still held in MEM and must not write back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            timed_out   <= 1'b0;
            load_data_q <= '0;
        end else begin
            if (in_access && !dbus_ack && !timeout_hit) cnt <= cnt + 1'b1;
            else                                        cnt <= '0;
            timed_out <= in_access && !dbus_ack && timeout_hit;
            if (in_access && dbus_ack && !mem_we_q) load_data_q <= load_value_m;
        end
    end

    assign dbus_req    = rst & in_access;
    assign mem_stall   = rst & stall_c;
    assign lsu_fault   = rst & (misalign_m | timed_out);
    assign dbus_we     = dbus_req & mem_we_q;
    assign dbus_be     = dbus_req ? be_m : 4'b0000;
    assign dbus_addr   = dbus_req ? {alu_q[ADDR_WITDH-1:2], 2'b00} : '0;
    assign dbus_wdata  = (dbus_req && mem_we_q) ? wdata_m : '0;

    assign reg_wem     = reg_we_q & ~misalign_m & ~timed_out;
    assign rdm         = rd_q;
    assign wb_ctrm     = wb_ctr_q;
    assign pcnm        = pcn_q;
    assign alu_resultm = alu_q;
    assign load_data   = load_data_q;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM stage of the 5-stage core; consumes the EX-stage result bundle.
- Registers the EX outputs into the EX/MEM pipeline register.
- Runs loads and stores on a req/ack data bus, and aligns and sign-extends load data.
- Returns alu_resultm to EX for forwarding; drives mem_stall to freeze the front end while a bus access is outstanding.

Parameters:
DATA_WITDH, 32, data path width (fixed at 32 for byte-lane logic)
ADDR_WITDH, 32, address and pc width
BUS_TIMEOUT, 16, max cycles an access waits for dbus_ack before abort (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
reg_wee  in  1  EX register-write enable
ope  in  3  funct3 of the EX instruction
mem_wee  in  1  store
wb_ctre  in  2  writeback select; 2'b01 = load
rde  in  5  destination register
pcne  in  ADDR_WITDH  pc+4 from EX
alu_result  in  DATA_WITDH  effective address / ALU value
rd2_ture  in  DATA_WITDH  forwarded store data
reg_wem  out  1  registered write enable (killed on fault)
rdm  out  5  registered rd
wb_ctrm  out  2  registered wb select
pcnm  out  ADDR_WITDH  registered pc+4
alu_resultm  out  DATA_WITDH  registered ALU result; forwarding source for EX
load_data  out  DATA_WITDH  aligned, extended load value
mem_stall  out  1  freeze IF/ID/EX and this register
lsu_fault  out  1  one-cycle pulse: misaligned/illegal op or bus timeout
dbus_req  out  1  access request
dbus_we  out  1  1 = write
dbus_addr  out  ADDR_WITDH  word-aligned address ({addr[31:2],2'b00})
dbus_be  out  4  byte enables
dbus_wdata  out  DATA_WITDH  lane-replicated store data
dbus_ack  in  1  access complete; rdata valid the same cycle
dbus_rdata  in  DATA_WITDH  read word

Behaviour:
- Reset (rst==0 at posedge): every EX/MEM register field cleared to 0. FSM goes to IDLE, timeout counter 0, load_data 0. All outputs are 0 while in reset, including dbus_req. An in-flight request is abandoned; the bus must accept a dropped req.
- Capture: on each posedge with mem_stall==0, all EX inputs load into the register. With mem_stall==1 the register holds.
- Access: the registered instruction is an access when mem_wem or wb_ctrm==01 (store wins if both). On capture of an access, the FSM goes to ACCESS.
- Ops:
  - ope 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - BU/HU are load-only; 011, 110, 111 are illegal.
  - A store with ope 100 or 101 is illegal.
- Alignment: H/HU need addr[0]==0; W needs addr[1:0]==00.
- Misaligned or illegal access:
  - No request is issued; FSM stays IDLE.
  - lsu_fault pulses in the first cycle the instruction is in MEM.
  - reg_wem forced 0; no stall.
- Byte enables:
  - B: 1<<addr[1:0].
  - H: 0011 or 1100.
  - W: 1111.
- wdata: B replicates byte x4; H replicates half x2; W passes through.
- FSM:
  - IDLE: dbus_req=0.
  - ACCESS:
    - dbus_req=1; addr, we, be and wdata stable until ack.
    - mem_stall = !dbus_ack (combinational); ack in the first ACCESS cycle gives zero extra latency.
    - Counter increments each cycle without ack.
  - On ack:
    - A load captures the extracted lane (sign-extended for B/H, zero-extended for BU/HU) into load_data at that posedge.
    - FSM goes to IDLE and the counter clears.
    - The next EX bundle is captured on the same edge.
  - Timeout: counter==BUS_TIMEOUT-1 without ack:
    - Abort: FSM goes to IDLE, mem_stall drops, lsu_fault pulses for one cycle.
    - reg_wem forced 0 for that instruction.
    - A late ack after abort is ignored (only sampled in ACCESS).
- Non-access instructions pass through in 1 cycle; load_data holds its previous value.
- alu_resultm, rdm and reg_wem stay valid and stable throughout a stall, so forwarding stays correct.
- Back-to-back accesses: ack on cycle N plus captured access gives ACCESS again with req held high across the edge; the new address appears at N+1.

Decomposition:
- Shared package:
  - funct3 localparams (LSU_B/H/W/BU/HU).
  - WB_ALU=2'b00, WB_MEM=2'b01, WB_PC=2'b10.
  - FSM state encodings IDLE/ACCESS.
- One sub-module: lsu_align. Combinational be/wdata generation, load extract/extend, and the misalign/illegal flag; shared for store and load paths.
- FSM, counter and pipeline register stay in mem_lsu.

Test Plan:
- SW rd2_ture=0xDEADBEEF, addr 0x104, ack same cycle -> dbus_req 1 cycle, be=1111, addr 0x104, wdata 0xDEADBEEF, mem_stall never 1.
- LB addr 0x203, rdata 0x80FF_0000, ack after 3 wait cycles -> mem_stall=1 for 3 cycles with addr/alu_resultm stable, load_data=0xFFFFFF80; LBU on the same data -> 0x00000080.
- SH addr 0x102 data 0x1234ABCD -> be=1100, wdata 0xABCDABCD; LH addr 0x101 -> no req, lsu_fault pulse, reg_wem=0.
- Load with no ack, BUS_TIMEOUT=16 -> stall exactly 16 cycles, then lsu_fault pulse, req low, reg_wem=0; an ack injected one cycle later has no effect.
- rst low during ACCESS wait -> next cycle dbus_req=0, mem_stall=0, all outputs 0; after release an ALU op passes through in 1 cycle.
- Back-to-back LW 0x10 then SW 0x14, both zero-wait -> req stays high 2 consecutive cycles, addresses 0x10 then 0x14, no stall.
